// File: rtl/addac_pkg.sv
// rtl/addac_pkg.sv - shared types and sizing helpers for the addac collector
//
// Purpose : collector FSM state type, default word width, counter sizing.
// Ports   : none (package).

package addac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } collector_state_t;

  localparam int ADDAC_WIDTH = 8;

  // The bit counter has to reach WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/addac_collector.sv
// rtl/addac_collector.sv - serial-to-parallel collector for the bit-serial adder
//
// Purpose : gathers WIDTH serial sum bits (LSB first) plus the final carry into
//           a parallel word and offers it through a valid/ready handshake.
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous active-low reset
//           start      - open a new frame (aborts a partial one), clears overrun
//           bit_valid  - y_in/cout_in carry a serial bit this cycle
//           y_in       - serial sum bit, LSB first
//           cout_in    - carry-out, taken with the WIDTH-th bit only
//           out_ready  - consumer takes the word this cycle
//           out_valid  - word held and valid
//           out_word   - assembled sum, zero whenever no word is held
//           out_carry  - carry captured with the final bit
//           busy       - frame being collected
//           overrun    - sticky, a bit arrived while idle or holding a word

module addac_collector
  import addac_pkg::*;
#(
  parameter int WIDTH = ADDAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             y_in,
  input  logic             cout_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             out_carry,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  collector_state_t state, state_next;

  logic [CW-1:0]    cnt;
  // Only WIDTH-1 bits are ever stored: the final bit goes straight into out_word.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] shifted;
  logic             clear_frame;
  logic             shift_bit;
  logic             last_bit;
  logic             xfer;

  always_comb begin
    state_next  = state;
    clear_frame = 1'b0;
    shift_bit   = 1'b0;
    last_bit    = 1'b0;
    xfer        = 1'b0;
    shifted     = {y_in, sr};

    case (state)
      IDLE: begin
        if (start) begin
          state_next  = SHIFT;
          clear_frame = 1'b1;
        end
      end
      SHIFT: begin
        // start wins over a coincident bit: the frame restarts empty.
        if (start) begin
          clear_frame = 1'b1;
        end else if (bit_valid) begin
          shift_bit = 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            last_bit   = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // start without out_ready is ignored so the held result is never lost.
        if (out_ready) begin
          xfer = 1'b1;
          if (start) begin
            state_next  = SHIFT;
            clear_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      sr        <= '0;
      out_word  <= '0;
      out_carry <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clear_frame) begin
        cnt <= '0;
        sr  <= '0;
      end else if (shift_bit) begin
        cnt <= cnt + CW'(1);
        sr  <= shifted[WIDTH-1:1];
      end

      if (last_bit) begin
        out_word  <= shifted;
        out_carry <= cout_in;
      end else if (xfer) begin
        out_word <= '0;
      end

      // Clear beats set when start and a stray bit coincide.
      if (start) begin
        overrun <= 1'b0;
      end else if (bit_valid && state != SHIFT) begin
        overrun <= 1'b1;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_addac_collector.sv
// tb/tb_addac_collector.sv - self-checking bench for addac_collector

module tb_addac_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         bit_valid = 1'b0;
  logic         y_in = 1'b0;
  logic         cout_in = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_word;
  logic         out_carry;
  logic         busy;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is a list of received bits; a result is either
  // held or not. The word value is rebuilt from the list by weighting.
  bit m_collecting;
  bit m_held;
  bit m_ov;
  bit m_carry;
  int m_word;
  bit bitq[$];

  addac_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .y_in      (y_in),
    .cout_in   (cout_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_carry (out_carry),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_collecting = 0;
    m_held       = 0;
    m_ov         = 0;
    m_carry      = 0;
    m_word       = 0;
    bitq.delete();
  endtask

  task automatic model_step(input bit st, input bit bv, input bit y, input bit c, input bit rdy);
    if (st)                        m_ov = 0;
    else if (bv && !m_collecting)  m_ov = 1;

    if (m_held) begin
      if (rdy) begin
        m_held = 0;
        m_word = 0;
        if (st) begin
          m_collecting = 1;
          bitq.delete();
        end
      end
    end else if (st) begin
      m_collecting = 1;
      bitq.delete();
    end else if (m_collecting && bv) begin
      bitq.push_back(y);
      if (bitq.size() == W) begin
        m_word = 0;
        for (int i = 0; i < W; i++) m_word += int'(bitq[i]) * (1 << i);
        m_carry      = c;
        m_held       = 1;
        m_collecting = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("out_valid", 32'(out_valid), 32'(m_held));
    check("out_word",  32'(out_word),  32'(m_word));
    check("busy",      32'(busy),      32'(m_collecting));
    check("overrun",   32'(overrun),   32'(m_ov));
    if (m_held) check("out_carry", 32'(out_carry), 32'(m_carry));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare.
  task automatic drive(input bit st, input bit bv, input bit y, input bit c, input bit rdy);
    start = st; bit_valid = bv; y_in = y; cout_in = c; out_ready = rdy;
    @(posedge clk);
    model_step(st, bv, y, c, rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit carry, input int gap);
    logic [W-1:0] wv;
    wv = word;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) begin
      repeat (gap) drive(0, 0, 0, 0, 0);
      drive(0, 1, wv[i], (i == W - 1) ? carry : 1'b0, 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_model();
    check("reset_carry", 32'(out_carry), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame
    send_frame(8'hA5, 1'b1, 0);
    check("basic_word",  32'(out_word),  32'hA5);
    check("basic_carry", 32'(out_carry), 32'd1);
    check("basic_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 0, 0, 1);
    check("basic_done_valid", 32'(out_valid), 32'd0);
    check("basic_overrun",    32'(overrun),   32'd0);

    // Gapped input
    send_frame(8'hA5, 1'b1, 2);
    check("gap_word", 32'(out_word), 32'hA5);
    drive(0, 0, 0, 0, 1);

    // Backpressure and overrun
    send_frame(8'h3C, 1'b0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("bp_overrun", 32'(overrun),   32'd1);
    check("bp_word",    32'(out_word),  32'h3C);
    check("bp_valid",   32'(out_valid), 32'd1);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    check("bp_ov_clear", 32'(overrun), 32'd0);

    // Abort mid-frame, then a full frame
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
    send_frame(8'hC3, 1'b0, 0);
    check("abort_word",  32'(out_word),  32'hC3);
    check("abort_carry", 32'(out_carry), 32'd0);
    drive(0, 0, 0, 0, 1);

    // Back-to-back frames
    send_frame(8'hA5, 1'b1, 0);
    drive(1, 0, 0, 0, 1);
    check("b2b_busy",  32'(busy),      32'd1);
    check("b2b_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < W; i++) drive(0, 1, (i < 4), 0, 0);
    check("b2b_word", 32'(out_word), 32'h0F);
    drive(0, 0, 0, 0, 1);

    // Asynchronous reset mid-frame
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_model();
    check("rst_carry", 32'(out_carry), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_frame(8'hFF, 1'b1, 0);
    check("rst_word",  32'(out_word),  32'hFF);
    check("rst_carry2", 32'(out_carry), 32'd1);
    drive(0, 0, 0, 0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
